nx_msg_encoder: RTL and testbench
=================================

// Module: nx_msg_encoder
//
// PURPOSE
// - Host-side message encoder at the mesh edge; the transmit counterpart of the node message decoder.
// - Turns host commands into nx_message_t messages and streams them over a valid/ready link into a mesh boundary inbound port.
// - Commands: instruction load, output mapping, signal state.
// - Optional column broadcast emits one message per column of the addressed row.
//
// PARAMETERS
// - ADDR_ROW_WIDTH  4   width of row address
// - ADDR_COL_WIDTH  4   width of column address
// - COLUMNS         4   columns targeted by broadcast (<= 2**ADDR_COL_WIDTH)
// - INSTR_WIDTH    21   width of instruction payload
// - INPUTS         32   node inputs; index width $clog2(INPUTS)
// - OUTPUTS        32   node outputs; index width $clog2(OUTPUTS)
//
// PORTS
// - clk_i            in   1                   clock
// - rst_ni           in   1                   reset, synchronous, active-low
// - idle_o           out  1                   encoder idle (registered)
// - error_o          out  1                   sticky: reserved command type seen
// - sent_count_o     out  32                  messages accepted downstream
// - cmd_type_i       in   2                   0 LOAD_INSTR, 1 MAP_OUTPUT, 2 SIG_STATE, 3 reserved
// - cmd_row_i        in   ADDR_ROW_WIDTH      destination row
// - cmd_col_i        in   ADDR_COL_WIDTH      destination column (ignored when cmd_bcast_i)
// - cmd_bcast_i      in   1                   replicate to columns 0..COLUMNS-1
// - cmd_instr_i      in   INSTR_WIDTH         instruction word (LOAD_INSTR)
// - cmd_idx_i        in   $clog2(OUTPUTS)     output index (MAP_OUTPUT) / signal index (SIG_STATE, LSBs)
// - cmd_tgt_row_i    in   ADDR_ROW_WIDTH      mapping target row
// - cmd_tgt_col_i    in   ADDR_COL_WIDTH      mapping target column
// - cmd_tgt_idx_i    in   $clog2(INPUTS)      mapping target input index
// - cmd_seq_i        in   1                   target / signal is sequential
// - cmd_state_i      in   1                   signal state (SIG_STATE)
// - cmd_valid_i      in   1                   command valid
// - cmd_ready_o      out  1                   command accepted when valid && ready
// - msg_data_o       out  nx_message_t        encoded message
// - msg_valid_o      out  1                   message valid
// - msg_ready_i      in   1                   mesh port ready
//
// BEHAVIOUR
// - Reset (rst_ni low at clk edge) values:
//   - FSM IDLE; msg_valid_o=0; msg_data_o='0; cmd_ready_o=0.
//   - error_o=0; sent_count_o=0; idle_o=0, rising to 1 the cycle after reset.
// - Reset mid-burst drops the command in flight and any held message; nothing resumes.
// - Output register: loads when !msg_valid_o || msg_ready_i.
//   - msg_data_o/msg_valid_o hold stable while valid && !ready.
//   - Sustains one message per cycle.
// - FSM IDLE:
//   - cmd_ready_o = output register loadable.
//   - On accept, the command is latched into the command register.
//   - Non-broadcast: message driven on msg_valid_o the next cycle (latency 1); FSM stays IDLE (back-to-back commands ok).
//   - Broadcast: first message (col 0) loaded, column counter set to 1, go BCAST.
// - FSM BCAST:
//   - cmd_ready_o=0.
//   - Each output-register load emits the latched command with col = counter; counter increments.
//   - Load of col COLUMNS-1 returns to IDLE.
//   - COLUMNS==1 never enters BCAST.
// - Reserved type 3: accepted, no message emitted, error_o set (cleared only by reset).
// - Header fields on every message: row, col, command.
// - Payload by type, packed MSB-first per the package structs, unused bits zero:
//   - LOAD_INSTR: instruction.
//   - MAP_OUTPUT: idx, tgt_row, tgt_col, tgt_idx, seq.
//   - SIG_STATE: idx[$clog2(INPUTS)-1:0], seq, state.
// - sent_count_o increments on each msg_valid_o && msg_ready_i; wraps 2**32-1 -> 0.
// - idle_o = registered (FSM IDLE && !msg_valid_o && !cmd_valid_i).
//
// STRUCTURE
// - Shared package nx_common additions:
//   - nx_command_t enum.
//   - Payload structs nx_msg_load_instr_t, nx_msg_map_output_t, nx_msg_sig_state_t.
//   - NX_CMD_RESERVED constant.
// - Sub-module nx_msg_encoder_pack: combinational latched-command + column -> nx_message_t.
// - Top: FSM, column counter, command register, output register, counters.
//
// TESTING
// - Reset, then LOAD_INSTR row 2 col 3 instr 0x1ABCD, ready=1
//   -> one message next cycle: row 2, col 3, cmd LOAD_INSTR, payload 0x1ABCD; sent_count_o=1.
// - 8 back-to-back SIG_STATE cmds, ready=1 -> 8 messages on 8 consecutive cycles; cmd_ready_o never drops.
// - MAP_OUTPUT bcast row 1, COLUMNS=4, ready toggling 1010...
//   -> cols 0,1,2,3 in order, data stable while stalled; cmd_ready_o=0 until col 3 loads.
// - msg_ready_i=0 for 5 cycles with a message held -> msg_data_o unchanged; cmd_ready_o=0; no command lost.
// - cmd_type_i=3 -> cmd accepted, no msg_valid_o, error_o=1 and stays 1.
// - Assert rst_ni low mid-broadcast (after col 1)
//   -> next cycle msg_valid_o=0, sent_count_o=0, FSM IDLE; a new command works normally.

Source files
------------

// File: rtl/nx_msg_encoder_pkg.sv
// Shared types for the mesh-edge message encoder: command codes, payload
// layouts and the on-link message format.
package nx_msg_encoder_pkg;

  localparam int NX_ROW_W     = 4;
  localparam int NX_COL_W     = 4;
  localparam int NX_INSTR_W   = 21;
  localparam int NX_IN_IDX_W  = 5;
  localparam int NX_OUT_IDX_W = 5;
  localparam int NX_PAYLOAD_W = NX_INSTR_W;

  typedef enum logic [1:0] {
    NX_CMD_LOAD_INSTR = 2'd0,
    NX_CMD_MAP_OUTPUT = 2'd1,
    NX_CMD_SIG_STATE  = 2'd2
  } nx_command_t;

  localparam logic [1:0] NX_CMD_RESERVED = 2'd3;

  typedef struct packed {
    logic [NX_INSTR_W-1:0] instr;
  } nx_msg_load_instr_t;

  typedef struct packed {
    logic [NX_OUT_IDX_W-1:0] idx;
    logic [NX_ROW_W-1:0]     tgt_row;
    logic [NX_COL_W-1:0]     tgt_col;
    logic [NX_IN_IDX_W-1:0]  tgt_idx;
    logic                    seq;
  } nx_msg_map_output_t;

  typedef struct packed {
    logic [NX_IN_IDX_W-1:0] idx;
    logic                   seq;
    logic                   state;
  } nx_msg_sig_state_t;

  typedef struct packed {
    logic [NX_ROW_W-1:0]     row;
    logic [NX_COL_W-1:0]     col;
    nx_command_t             command;
    logic [NX_PAYLOAD_W-1:0] payload;
  } nx_message_t;

  // Latched command; column lives in the broadcast counter, not here.
  typedef struct packed {
    logic [1:0]              kind;
    logic [NX_ROW_W-1:0]     row;
    logic [NX_INSTR_W-1:0]   instr;
    logic [NX_OUT_IDX_W-1:0] idx;
    logic [NX_ROW_W-1:0]     tgt_row;
    logic [NX_COL_W-1:0]     tgt_col;
    logic [NX_IN_IDX_W-1:0]  tgt_idx;
    logic                    seq;
    logic                    state;
  } nx_cmd_t;

endpackage

// File: rtl/nx_msg_encoder_pack.sv
// Combinational command + column -> message formatter. Payload structs sit
// in the payload LSBs with the unused upper bits zero.
module nx_msg_encoder_pack
  import nx_msg_encoder_pkg::*;
(
  input  nx_cmd_t             cmd,
  input  logic [NX_COL_W-1:0] col,
  output nx_message_t         msg
);

  nx_msg_map_output_t mo;
  nx_msg_sig_state_t  ss;

  always_comb begin
    mo = '{idx: cmd.idx, tgt_row: cmd.tgt_row, tgt_col: cmd.tgt_col,
           tgt_idx: cmd.tgt_idx, seq: cmd.seq};
    ss = '{idx: cmd.idx[NX_IN_IDX_W-1:0], seq: cmd.seq, state: cmd.state};
  end

  always_comb begin
    msg         = '0;
    msg.row     = cmd.row;
    msg.col     = col;
    msg.command = nx_command_t'(cmd.kind);
    case (cmd.kind)
      NX_CMD_LOAD_INSTR: msg.payload = cmd.instr;
      NX_CMD_MAP_OUTPUT: msg.payload = {{(NX_PAYLOAD_W-$bits(mo)){1'b0}}, mo};
      NX_CMD_SIG_STATE:  msg.payload = {{(NX_PAYLOAD_W-$bits(ss)){1'b0}}, ss};
      default:           msg.payload = '0;
    endcase
  end

endmodule

// File: rtl/nx_msg_encoder.sv
// Host-side message encoder: accepts commands, optionally replicates them
// across the columns of a row, and streams messages over a valid/ready link.
module nx_msg_encoder
  import nx_msg_encoder_pkg::*;
#(
  parameter int ADDR_ROW_WIDTH = 4,
  parameter int ADDR_COL_WIDTH = 4,
  parameter int COLUMNS        = 4,
  parameter int INSTR_WIDTH    = 21,
  parameter int INPUTS         = 32,
  parameter int OUTPUTS        = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  output logic                       idle_o,
  output logic                       error_o,
  output logic [31:0]                sent_count_o,
  input  logic [1:0]                 cmd_type_i,
  input  logic [ADDR_ROW_WIDTH-1:0]  cmd_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]  cmd_col_i,
  input  logic                       cmd_bcast_i,
  input  logic [INSTR_WIDTH-1:0]     cmd_instr_i,
  input  logic [$clog2(OUTPUTS)-1:0] cmd_idx_i,
  input  logic [ADDR_ROW_WIDTH-1:0]  cmd_tgt_row_i,
  input  logic [ADDR_COL_WIDTH-1:0]  cmd_tgt_col_i,
  input  logic [$clog2(INPUTS)-1:0]  cmd_tgt_idx_i,
  input  logic                       cmd_seq_i,
  input  logic                       cmd_state_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  output nx_message_t                msg_data_o,
  output logic                       msg_valid_o,
  input  logic                       msg_ready_i
);

  typedef enum logic {S_IDLE, S_BCAST} state_t;

  state_t                    state, state_nx;
  nx_cmd_t                   cmd_in, cmd_q, pack_src;
  nx_message_t               pack_msg;
  logic [ADDR_COL_WIDTH-1:0] col_cnt, pack_col;
  logic                      load, accept, rsvd, go_bcast, last_col;

  always_comb begin
    cmd_in = '{kind: cmd_type_i, row: cmd_row_i, instr: cmd_instr_i,
               idx: cmd_idx_i, tgt_row: cmd_tgt_row_i, tgt_col: cmd_tgt_col_i,
               tgt_idx: cmd_tgt_idx_i, seq: cmd_seq_i, state: cmd_state_i};
  end

  assign load     = !msg_valid_o || msg_ready_i;
  assign rsvd     = (cmd_type_i == NX_CMD_RESERVED);
  assign last_col = (col_cnt == ADDR_COL_WIDTH'(COLUMNS-1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (go_bcast)         state_nx = S_BCAST;
      S_BCAST: if (load && last_col) state_nx = S_IDLE;
      default:                       state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = rst_ni && (state == S_IDLE) && load;
    accept      = cmd_valid_i && cmd_ready_o;
    go_bcast    = accept && !rsvd && cmd_bcast_i && (COLUMNS > 1);
  end

  // In IDLE the live command is packed directly so it leaves one cycle after accept.
  always_comb begin
    pack_src = (state == S_IDLE) ? cmd_in : cmd_q;
    pack_col = (state == S_BCAST) ? col_cnt : (cmd_bcast_i ? '0 : cmd_col_i);
  end

  nx_msg_encoder_pack u_pack (
    .cmd (pack_src),
    .col (pack_col),
    .msg (pack_msg)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      msg_valid_o  <= 1'b0;
      msg_data_o   <= '0;
      col_cnt      <= '0;
      cmd_q        <= '0;
      error_o      <= 1'b0;
      sent_count_o <= '0;
      idle_o       <= 1'b0;
    end else begin
      if (accept)               cmd_q        <= cmd_in;
      if (accept && rsvd)       error_o      <= 1'b1;
      if (msg_valid_o && msg_ready_i) sent_count_o <= sent_count_o + 32'd1;
      idle_o <= (state == S_IDLE) && !msg_valid_o && !cmd_valid_i;
      if (load) begin
        if (state == S_BCAST) begin
          msg_valid_o <= 1'b1;
          msg_data_o  <= pack_msg;
          col_cnt     <= col_cnt + 1'b1;
        end else if (accept && !rsvd) begin
          msg_valid_o <= 1'b1;
          msg_data_o  <= pack_msg;
          col_cnt     <= ADDR_COL_WIDTH'(1);
        end else begin
          msg_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_nx_msg_encoder.sv
// Scoreboard bench for nx_msg_encoder: directed commands push hand-computed
// messages; a negedge monitor pops and compares on every link handshake.
module tb_nx_msg_encoder;
  import nx_msg_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        idle, error, cmd_bcast, cmd_seq, cmd_state, cmd_valid, cmd_ready;
  logic        msg_valid, msg_ready;
  logic [31:0] sent_count;
  logic [1:0]  cmd_type;
  logic [3:0]  cmd_row, cmd_col, cmd_tgt_row, cmd_tgt_col;
  logic [20:0] cmd_instr;
  logic [4:0]  cmd_idx, cmd_tgt_idx;
  nx_message_t msg_data;

  always #5 clk = ~clk;

  nx_msg_encoder dut (
    .clk_i(clk), .rst_ni(rst_ni), .idle_o(idle), .error_o(error),
    .sent_count_o(sent_count), .cmd_type_i(cmd_type), .cmd_row_i(cmd_row),
    .cmd_col_i(cmd_col), .cmd_bcast_i(cmd_bcast), .cmd_instr_i(cmd_instr),
    .cmd_idx_i(cmd_idx), .cmd_tgt_row_i(cmd_tgt_row), .cmd_tgt_col_i(cmd_tgt_col),
    .cmd_tgt_idx_i(cmd_tgt_idx), .cmd_seq_i(cmd_seq), .cmd_state_i(cmd_state),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .msg_data_o(msg_data),
    .msg_valid_o(msg_valid), .msg_ready_i(msg_ready)
  );

  int          errors = 0, checks = 0, cyc = 0, rmode = 0;
  bit          bcast_watch = 0;
  logic [30:0] exp_q[$];
  int          hs_log[$];

  localparam logic [30:0] SIG_EXP [8] = '{
    31'h28400000, 31'h28C00006, 31'h29400009, 31'h29C0000F,
    31'h2A400010, 31'h2AC00016, 31'h2B400019, 31'h2BC0001F};
  localparam logic [30:0] MAP_EXP [4] = '{
    31'h08228F23, 31'h08A28F23, 31'h09228F23, 31'h09A28F23};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Link-side ready pattern: 0 always ready, 1 toggling, 2 stalled.
  initial begin
    msg_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1:       msg_ready = ~msg_ready;
        2:       msg_ready = 1'b0;
        default: msg_ready = 1'b1;
      endcase
    end
  end

  initial begin : monitor
    logic        prev_v, prev_r;
    nx_message_t prev_d;
    logic [30:0] e;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bcast_watch && exp_q.size() >= 2) chk("bcast_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      if (prev_v && !prev_r) begin
        chk("hold_valid", {31'b0, msg_valid}, 32'd1);
        chk("hold_data", {1'b0, msg_data}, {1'b0, prev_d});
      end
      if (msg_valid && msg_ready) begin
        hs_log.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_msg: got %h expected none", msg_data);
        end else begin
          e = exp_q.pop_front();
          if (msg_data !== e) begin
            errors++;
            $display("FAIL msg: got %h expected %h", msg_data, e);
          end
        end
      end
      prev_v = msg_valid; prev_r = msg_ready; prev_d = msg_data;
    end
  end

  task automatic set_cmd(input logic [1:0] t, input logic [3:0] row, input logic [3:0] col,
                         input logic bc, input logic [20:0] instr, input logic [4:0] idx,
                         input logic [3:0] tr, input logic [3:0] tc, input logic [4:0] ti,
                         input logic sq, input logic st);
    cmd_type = t; cmd_row = row; cmd_col = col; cmd_bcast = bc; cmd_instr = instr;
    cmd_idx = idx; cmd_tgt_row = tr; cmd_tgt_col = tc; cmd_tgt_idx = ti;
    cmd_seq = sq; cmd_state = st;
  endtask

  // Hold cmd_valid until accepted; returns stalled cycles and the accept cycle.
  task automatic issue(output int waits, output int acc);
    waits = 0; acc = 0;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waits++;
      if (waits > 200) begin
        errors++; checks++;
        $display("FAIL issue_timeout: got no cmd_ready expected accept");
        break;
      end
    end
    @(posedge clk); acc = cyc; #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, a, tw;
    rst_ni = 1'b0; cmd_valid = 1'b0;
    set_cmd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_msg_valid", {31'b0, msg_valid}, 32'd0);
    chk("rst_msg_data", {1'b0, msg_data}, 32'd0);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_sent", sent_count, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd0);
    @(posedge clk); #1; rst_ni = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_idle", {31'b0, idle}, 32'd1);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Single LOAD_INSTR, latency 1
    hs_log.delete();
    exp_q.push_back(31'h1181ABCD);
    set_cmd(0, 2, 3, 0, 21'h1ABCD, 0, 0, 0, 0, 0, 0);
    issue(w, a);
    cmd_valid = 1'b0;
    drain("load");
    chk("load_latency", 32'(hs_log.size() > 0 ? hs_log[0] : -1), 32'(a + 1));
    @(negedge clk);
    chk("load_sent", sent_count, 32'd1);
    @(posedge clk); #1;

    // Back-to-back SIG_STATE
    hs_log.delete(); tw = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(SIG_EXP[i]);
      set_cmd(2, 5, 4'(i), 0, 0, 5'(i), 0, 0, 0, i[0], i[1]);
      issue(w, a);
      tw += w;
    end
    cmd_valid = 1'b0;
    drain("sig");
    chk("sig_ready_stalls", 32'(tw), 32'd0);
    chk("sig_count", 32'(hs_log.size()), 32'd8);
    chk("sig_consecutive", 32'(hs_log.size() == 8 ? hs_log[7] - hs_log[0] : -1), 32'd7);

    // MAP_OUTPUT broadcast with toggling ready
    @(negedge clk); rmode = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) exp_q.push_back(MAP_EXP[c]);
    set_cmd(1, 1, 4'hF, 1, 0, 5'h0A, 4'h3, 4'hC, 5'h11, 1, 0);
    issue(w, a);
    cmd_valid = 1'b0;
    bcast_watch = 1;
    drain("bcast");
    bcast_watch = 0;
    @(negedge clk); rmode = 0;
    @(posedge clk); #1;

    // Stall with message held; second command must wait and survive
    @(negedge clk); rmode = 2;
    @(posedge clk); #1;
    exp_q.push_back(31'h38800055);
    set_cmd(0, 7, 1, 0, 21'h00055, 0, 0, 0, 0, 0, 0);
    issue(w, a);
    exp_q.push_back(31'h0001FFFF);
    set_cmd(0, 0, 0, 0, 21'h1FFFF, 0, 0, 0, 0, 0, 0);
    fork
      issue(w, a);
      begin repeat (5) @(negedge clk); rmode = 0; end
    join
    cmd_valid = 1'b0;
    drain("stall");
    chk("stall_cmd_ready_low", {31'b0, (w >= 5)}, 32'd1);

    // Reserved type: accepted, nothing emitted, sticky error
    set_cmd(3, 1, 1, 0, 21'h1, 0, 0, 0, 0, 0, 0);
    issue(w, a);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rsvd_no_valid", {31'b0, msg_valid}, 32'd0);
    chk("rsvd_error", {31'b0, error}, 32'd1);
    @(posedge clk); #1;
    exp_q.push_back(31'h20000007);
    set_cmd(0, 4, 0, 0, 21'h00007, 0, 0, 0, 0, 0, 0);
    issue(w, a);
    cmd_valid = 1'b0;
    drain("after_rsvd");
    @(negedge clk);
    chk("rsvd_error_sticky", {31'b0, error}, 32'd1);
    @(posedge clk); #1;

    // Reset mid-broadcast after col 1 is loaded
    exp_q.push_back(31'h18000001);
    exp_q.push_back(31'h18800001);
    set_cmd(0, 3, 0, 1, 21'h00001, 0, 0, 0, 0, 0, 0);
    issue(w, a);
    cmd_valid = 1'b0;
    @(posedge clk); #1; rst_ni = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_valid", {31'b0, msg_valid}, 32'd0);
    chk("midrst_sent", sent_count, 32'd0);
    chk("midrst_error", {31'b0, error}, 32'd0);
    @(posedge clk); #1; rst_ni = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_idle", {31'b0, idle}, 32'd1);
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    exp_q.push_back(31'h01012345);
    set_cmd(0, 0, 2, 0, 21'h12345, 0, 0, 0, 0, 0, 0);
    issue(w, a);
    cmd_valid = 1'b0;
    drain("post_rst");
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_sent", sent_count, 32'd1);
    chk("post_rst_quiet", {31'b0, msg_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
